// File: rtl/uart_boot_loader_pkg.sv
// Shared boot-loader types: frame-parser states and the sync marker.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} boot_state_t;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/boot_word_packer.sv
// Packs payload bytes little-endian into 32-bit words at consecutive word addresses.
// Latency: one registered write strobe the cycle after a word's 4th byte; accepts 1 byte/cycle, never stalls.
module boot_word_packer
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [31:0]           word,
  output logic                  word_valid,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  byte_last
);

  logic [1:0]  byte_idx;
  logic [23:0] shift;

  assign byte_last = (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx   <= '0;
      shift      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_addr  <= '0;
      word_count <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx   <= '0;
        word_count <= '0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        // Earlier bytes shift down so byte k ends up in bits [8k+7:8k].
        shift    <= {byte_data, shift[23:8]};
        if (byte_last) begin
          word       <= {byte_data, shift};
          word_valid <= 1'b1;
          word_addr  <= word_count[ADDR_WIDTH-1:0];
          word_count <= word_count + (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses SYNC/LEN/payload/CSUM frames into instruction-memory writes, holds the CPU until a good frame.
// Latency: writes and status one cycle after the triggering byte; absorbs back-to-back strobes, no backpressure.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  boot_state_t state, next_state;

  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [15:0]         len_rx;
  logic [7:0]          sum;
  logic [TW-1:0]       idle_count;
  logic [ADDR_WIDTH:0] word_count;
  logic                byte_last;
  logic                frame_active;
  logic                timeout_hit;
  logic                data_byte;
  logic                enter_len0;

  assign len_rx       = {rx_byte, len_lo};
  assign frame_active = state inside {LEN0, LEN1, DATA, CSUM};
  // A byte on the final idle cycle wins over the timeout.
  assign timeout_hit  = frame_active && !rx_valid && (idle_count == TIMEOUT_LAST);
  assign data_byte    = rx_valid && (state == DATA);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    enter_len0 = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (rx_valid && rx_byte == BOOT_SYNC_BYTE) begin
          next_state = LEN0;
          enter_len0 = 1'b1;
        end
      end
      LEN0: if (rx_valid) next_state = LEN1;
      LEN1: begin
        if (rx_valid)
          next_state = (len_rx == 16'd0 || 32'(len_rx) > MAX_WORDS) ? ERROR : DATA;
      end
      DATA: begin
        if (rx_valid && byte_last && 32'(word_count) == 32'(len) - 32'd1)
          next_state = CSUM;
      end
      CSUM: if (rx_valid) next_state = (rx_byte == sum) ? DONE : ERROR;
      default: next_state = IDLE;
    endcase
    if (timeout_hit) next_state = ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo     <= '0;
      len        <= '0;
      sum        <= '0;
      idle_count <= '0;
    end else begin
      idle_count <= (frame_active && !rx_valid) ? idle_count + TW'(1) : '0;
      if (state == LEN0 && rx_valid) len_lo <= rx_byte;
      if (state == LEN1 && rx_valid) len <= len_rx;
      if (enter_len0)     sum <= '0;
      else if (data_byte) sum <= sum + rx_byte;
    end
  end

  boot_word_packer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (enter_len0),
    .byte_valid(data_byte),
    .byte_data (rx_byte),
    .word      (mem_wdata),
    .word_valid(mem_we),
    .word_addr (mem_addr),
    .word_count(word_count),
    .byte_last (byte_last)
  );

  assign cpu_hold   = (state != DONE);
  assign load_done  = (state == DONE);
  assign load_error = (state == ERROR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frame stimulus with a queue-based write/status reference model.
module tb_uart_boot_loader;

  localparam int AW = 8;
  localparam int MW = 256;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  uart_boot_loader #(
    .ADDR_WIDTH    (AW),
    .MAX_WORDS     (MW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] pay[$];
  int         total = 0;
  int         bad   = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t w;
      w.addr = int'(mem_addr);
      w.data = mem_wdata;
      w.cyc  = cyc;
      got_q.push_back(w);
    end
  end

  task automatic send_byte(input logic [7:0] b, output int c);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] pay_sum();
    int s = 0;
    foreach (pay[i]) s += int'(pay[i]);
    return 8'(s % 256);
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return 32'(pay[4*i]) + 32'(pay[4*i+1]) * 256 + 32'(pay[4*i+2]) * 65536 +
           32'(pay[4*i+3]) * 16777216;
  endfunction

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic expect_word(input int j, input int len, input int c);
    wr_t w;
    if (j % 4 == 3 && len >= 1 && len <= MW) begin
      w.addr = j / 4;
      w.data = word_of(j / 4);
      w.cyc  = c;
      exp_q.push_back(w);
    end
  endtask

  // Sends SYNC, LEN and the first n_send payload bytes, optionally the checksum.
  task automatic send_frame(input int len, input int n_send, input bit with_csum,
                            input logic [7:0] csum, input int gap_max);
    int          c;
    logic [15:0] l;
    l = 16'(len);
    send_byte(8'hA5, c);
    send_byte(l[7:0], c);
    send_byte(l[15:8], c);
    for (int j = 0; j < n_send; j++) begin
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      send_byte(pay[j], c);
      expect_word(j, len, c);
    end
    if (with_csum) begin
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      send_byte(csum, c);
    end
  endtask

  function automatic int write_errs();
    int e = 0;
    if (got_q.size() != exp_q.size()) return 1 + exp_q.size();
    foreach (exp_q[i])
      if (got_q[i].addr != exp_q[i].addr || got_q[i].data !== exp_q[i].data ||
          got_q[i].cyc != exp_q[i].cyc) e++;
    return e;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(3);
    reset = 1'b0;
    total++;
    if ({mem_we, mem_addr, mem_wdata} !== 41'd0) begin
      bad++;
      $display("FAIL reset_datapath: got we=%b addr=%0d data=%h, required 0/0/0",
               mem_we, mem_addr, mem_wdata);
    end
    total++;
    if ({cpu_hold, load_done, load_error} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags: got hold/done/err=%b, required 100",
               {cpu_hold, load_done, load_error});
    end
  endtask

  task automatic test_garbage_and_len();
    int c, e;
    send_byte(8'h00, c);
    send_byte(8'hFF, c);
    fill_random(12);
    send_frame(3, 12, 1'b1, pay_sum(), 0);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL garbage_frame: got done/err/hold=%b, required 100",
               {load_done, load_error, cpu_hold});
    end
    total++;
    e = write_errs();
    if (e != 0) begin
      bad++;
      $display("FAIL garbage_writes: got %0d writes, required %0d, %0d differ",
               got_q.size(), exp_q.size(), e);
    end
    got_q.delete();
    exp_q.delete();
    send_byte(8'hA5, c);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b001) begin
      bad++;
      $display("FAIL resync_from_done: got done/err/hold=%b, required 001",
               {load_done, load_error, cpu_hold});
    end
    send_byte(8'h00, c);
    send_byte(8'h00, c);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b011) begin
      bad++;
      $display("FAIL len_zero: got done/err/hold=%b, required 011",
               {load_done, load_error, cpu_hold});
    end
    send_frame(MW + 1, 0, 1'b0, 8'h00, 0);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b011) begin
      bad++;
      $display("FAIL len_too_big: got done/err/hold=%b, required 011",
               {load_done, load_error, cpu_hold});
    end
    idle(3);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL len_err_writes: got %0d writes, required 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_good_frame();
    int e;
    pay.delete();
    for (int i = 1; i <= 8; i++) pay.push_back(8'(i));
    send_frame(2, 8, 1'b1, 8'h24, 0);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL good_flags: got done/err/hold=%b, required 100",
               {load_done, load_error, cpu_hold});
    end
    total++;
    if (got_q.size() != 2 || got_q[0].data !== 32'h04030201 || got_q[0].addr != 0 ||
        got_q[1].data !== 32'h08070605 || got_q[1].addr != 1) begin
      bad++;
      $display("FAIL good_words: got %0d writes, required 04030201@0 08070605@1",
               got_q.size());
    end
    total++;
    e = write_errs();
    if (e != 0) begin
      bad++;
      $display("FAIL good_write_timing: got %0d writes, required %0d, %0d differ",
               got_q.size(), exp_q.size(), e);
    end
    got_q.delete();
    exp_q.delete();
    total++;
    if (mem_addr !== 8'd1 || mem_wdata !== 32'h08070605) begin
      bad++;
      $display("FAIL good_hold: got addr=%0d data=%h, required 1/08070605",
               mem_addr, mem_wdata);
    end
  endtask

  task automatic test_bad_csum();
    int e;
    pay.delete();
    for (int i = 1; i <= 8; i++) pay.push_back(8'(i));
    send_frame(2, 8, 1'b1, 8'h25, 0);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b011) begin
      bad++;
      $display("FAIL bad_csum_flags: got done/err/hold=%b, required 011",
               {load_done, load_error, cpu_hold});
    end
    total++;
    e = write_errs();
    if (e != 0) begin
      bad++;
      $display("FAIL bad_csum_writes: got %0d writes, required %0d, %0d differ",
               got_q.size(), exp_q.size(), e);
    end
    got_q.delete();
    exp_q.delete();
    send_frame(2, 8, 1'b1, 8'h24, 0);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL recover_flags: got done/err/hold=%b, required 100",
               {load_done, load_error, cpu_hold});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_frames();
    int         len, e;
    bit         corrupt;
    logic [7:0] csum;
    logic [2:0] want;
    for (int k = 0; k < 6; k++) begin
      len     = int'($urandom_range(6, 1));
      corrupt = 1'($urandom_range(1, 0));
      fill_random(len * 4);
      csum = pay_sum();
      if (corrupt) csum = csum + 8'($urandom_range(255, 1));
      want = (csum == pay_sum()) ? 3'b100 : 3'b011;
      send_frame(len, len * 4, 1'b1, csum, 3);
      total++;
      if ({load_done, load_error, cpu_hold} !== want) begin
        bad++;
        $display("FAIL rand_flags[%0d]: got done/err/hold=%b, required %b",
                 k, {load_done, load_error, cpu_hold}, want);
      end
      total++;
      e = write_errs();
      if (e != 0) begin
        bad++;
        $display("FAIL rand_writes[%0d]: got %0d writes, required %0d, %0d differ",
                 k, got_q.size(), exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int c, e;
    fill_random(8);
    send_frame(2, 5, 1'b0, 8'h00, 0);
    idle(TO - 1);
    total++;
    if (load_error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got err=%b after %0d idle cycles, required 0",
               load_error, TO - 1);
    end
    idle(1);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b011) begin
      bad++;
      $display("FAIL timeout_fire: got done/err/hold=%b, required 011",
               {load_done, load_error, cpu_hold});
    end
    total++;
    e = write_errs();
    if (e != 0) begin
      bad++;
      $display("FAIL timeout_writes: got %0d writes, required %0d, %0d differ",
               got_q.size(), exp_q.size(), e);
    end
    got_q.delete();
    exp_q.delete();
    fill_random(8);
    send_frame(2, 5, 1'b0, 8'h00, 0);
    idle(TO - 1);
    send_byte(pay[5], c);
    total++;
    if (load_error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rescue: got err=%b, required 0", load_error);
    end
    for (int j = 6; j < 8; j++) begin
      send_byte(pay[j], c);
      expect_word(j, 2, c);
    end
    send_byte(pay_sum(), c);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_rescue_done: got done/err/hold=%b, required 100",
               {load_done, load_error, cpu_hold});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int e;
    fill_random(MW * 4);
    send_frame(MW, MW * 4, 1'b1, pay_sum(), 0);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_flags: got done/err/hold=%b, required 100",
               {load_done, load_error, cpu_hold});
    end
    total++;
    e = write_errs();
    if (e != 0) begin
      bad++;
      $display("FAIL b2b_writes: got %0d writes, required %0d, %0d differ",
               got_q.size(), exp_q.size(), e);
    end
    total++;
    if (mem_addr !== 8'(MW - 1) || got_q.size() != MW) begin
      bad++;
      $display("FAIL b2b_last_addr: got addr=%0d count=%0d, required %0d/%0d",
               mem_addr, got_q.size(), MW - 1, MW);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int e;
    fill_random(16);
    send_frame(4, 6, 1'b0, 8'h00, 0);
    reset = 1'b1;
    idle(1);
    total++;
    if ({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error} !== {41'd0, 3'b100}) begin
      bad++;
      $display("FAIL reset_mid: got we=%b addr=%0d data=%h hold/done/err=%b, required 0/0/0/100",
               mem_we, mem_addr, mem_wdata, {cpu_hold, load_done, load_error});
    end
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    fill_random(8);
    send_frame(2, 8, 1'b1, pay_sum(), 2);
    total++;
    if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL post_reset_flags: got done/err/hold=%b, required 100",
               {load_done, load_error, cpu_hold});
    end
    total++;
    e = write_errs();
    if (e != 0 || got_q.size() == 0 || got_q[0].addr != 0) begin
      bad++;
      $display("FAIL post_reset_writes: got %0d writes, required %0d from addr 0, %0d differ",
               got_q.size(), exp_q.size(), e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    test_reset();
    test_garbage_and_len();
    test_good_frame();
    test_bad_csum();
    test_random_frames();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
